// File: rtl/bench_bist_harness.sv
// ---------------------------------------------------------------------------
// bench_bist_harness
// Self-test harness for a synthesized benchmark core (CUT). It drives
// pseudo-random primary inputs from an LFSR, pulses the CUT reset, and
// compacts the CUT primary outputs into a MISR signature. At the end of a
// run the signature is compared against a golden value.
//
// Ports
//   blif_clk_net   : sole clock, rising edge
//   blif_reset_net : asynchronous active-high reset
//   start          : one-cycle run request (honoured in IDLE and DONE)
//   abort          : cancels a run in RESET_CUT or RUN
//   pat_count      : number of patterns to apply, sampled at start
//   lfsr_seed      : initial pattern, sampled at start (0 is replaced by 1)
//   expected_sig   : golden signature, compared while in DONE
//   po_vec         : CUT primary outputs
//   pi_vec         : CUT primary inputs (the LFSR register)
//   cut_rst        : registered active-high reset to the CUT
//   busy           : high in RESET_CUT and RUN
//   done           : high in DONE
//   pass           : valid with done, 1 when signature == expected_sig
//   signature      : current MISR contents
// RST_CYC must be 1 or more.
// ---------------------------------------------------------------------------
module bench_bist_harness #(
   parameter int unsigned       PI_W      = 18,
   parameter int unsigned       PO_W      = 19,
   parameter logic [PI_W-1:0]   LFSR_POLY = 18'h20400,
   parameter logic [PO_W-1:0]   MISR_POLY = 19'h40023,
   parameter int unsigned       RST_CYC   = 2
) (
   input  logic            blif_clk_net,
   input  logic            blif_reset_net,
   input  logic            start,
   input  logic            abort,
   input  logic [15:0]     pat_count,
   input  logic [PI_W-1:0] lfsr_seed,
   input  logic [PO_W-1:0] expected_sig,
   input  logic [PO_W-1:0] po_vec,
   output logic [PI_W-1:0] pi_vec,
   output logic            cut_rst,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [PO_W-1:0] signature
);

   localparam int unsigned CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RESET_CUT,
      RUN,
      DONE
   } state_t;

   state_t          state, state_n;
   logic [PI_W-1:0] lfsr, lfsr_n;
   logic [PO_W-1:0] misr, misr_n;
   logic [15:0]     cnt, cnt_n;
   logic [CW-1:0]   cyc, cyc_n;
   logic            cut_rst_q, cut_rst_n;

   logic [PI_W-1:0] lfsr_step;
   logic [PO_W-1:0] misr_step;
   logic [PI_W-1:0] seed_safe;

   always_comb begin
      lfsr_step = {lfsr[PI_W-2:0], ^(lfsr & LFSR_POLY)};
      misr_step = {misr[PO_W-2:0], ^(misr & MISR_POLY)} ^ po_vec;
      // An all-zero seed would lock the LFSR at zero.
      seed_safe = (lfsr_seed == '0) ? {{(PI_W-1){1'b0}}, 1'b1} : lfsr_seed;
   end

   always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
      if (blif_reset_net) begin
         state     <= IDLE;
         lfsr      <= '0;
         misr      <= '0;
         cnt       <= '0;
         cyc       <= '0;
         cut_rst_q <= 1'b0;
      end else begin
         state     <= state_n;
         lfsr      <= lfsr_n;
         misr      <= misr_n;
         cnt       <= cnt_n;
         cyc       <= cyc_n;
         cut_rst_q <= cut_rst_n;
      end
   end

   always_comb begin
      state_n = state;
      lfsr_n  = lfsr;
      misr_n  = misr;
      cnt_n   = cnt;
      cyc_n   = cyc;

      case (state)
         IDLE, DONE: begin
            // abort is ignored here, so start always wins in DONE
            if (start) begin
               state_n = RESET_CUT;
               cnt_n   = pat_count;
               lfsr_n  = seed_safe;
               misr_n  = '0;
               cyc_n   = '0;
            end
         end
         RESET_CUT: begin
            if (abort) begin
               state_n = IDLE;
               lfsr_n  = '0;
            end else if (cyc == CW'(RST_CYC - 1)) begin
               state_n = (cnt != '0) ? RUN : DONE;
            end else begin
               cyc_n = cyc + 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               // partial signature is kept; pi_vec returns to 0 in IDLE
               state_n = IDLE;
               lfsr_n  = '0;
            end else begin
               misr_n = misr_step;
               lfsr_n = lfsr_step;
               cnt_n  = cnt - 1'b1;
               if (cnt == 16'd1) state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase

      // cut_rst is registered from the next state so it is glitch-free
      cut_rst_n = (state_n == RESET_CUT);
   end

   assign pi_vec    = lfsr;
   assign signature = misr;
   assign cut_rst   = cut_rst_q;
   assign busy      = (state == RESET_CUT) || (state == RUN);
   assign done      = (state == DONE);
   assign pass      = (state == DONE) && (misr == expected_sig);

endmodule
